// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: en-gated h/v counters, decoded sync/blank,
// a DELAY-stage output pipeline, line/frame start pulses and a completed-frame counter.
module vga_timing_gen #(
    parameter int CNT_W          = 11,
    parameter int HL_TOTAL_TIME  = 1344,
    parameter int HL_BLANK_START = 1024,
    parameter int HL_SYNC_START  = 1048,
    parameter int HL_SYNC_END    = 1184,
    parameter int VL_TOTAL_TIME  = 806,
    parameter int VL_BLANK_START = 768,
    parameter int VL_SYNC_START  = 771,
    parameter int VL_SYNC_END    = 777,
    parameter bit HSYNC_POL      = 1'b0,
    parameter bit VSYNC_POL      = 1'b0,
    parameter int DELAY          = 1,
    parameter int FRAME_W        = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic [CNT_W-1:0]   hcount,
    output logic [CNT_W-1:0]   vcount,
    output logic               hsync,
    output logic               vsync,
    output logic               hblnk,
    output logic               vblnk,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    if (!(HL_BLANK_START < HL_SYNC_START && HL_SYNC_START < HL_SYNC_END &&
          HL_SYNC_END <= HL_TOTAL_TIME)) begin : g_bad_h
        $error("vga_timing_gen: invalid horizontal timing parameters");
    end
    if (!(VL_BLANK_START < VL_SYNC_START && VL_SYNC_START < VL_SYNC_END &&
          VL_SYNC_END <= VL_TOTAL_TIME)) begin : g_bad_v
        $error("vga_timing_gen: invalid vertical timing parameters");
    end
    if (DELAY < 1 || DELAY > 4) begin : g_bad_delay
        $error("vga_timing_gen: DELAY must be 1..4");
    end

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HL_TOTAL_TIME - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VL_TOTAL_TIME - 1);
    localparam logic [CNT_W:0]   H_BLANK  = (CNT_W+1)'(HL_BLANK_START);
    localparam logic [CNT_W:0]   H_SYNC_S = (CNT_W+1)'(HL_SYNC_START);
    localparam logic [CNT_W:0]   H_SYNC_E = (CNT_W+1)'(HL_SYNC_END);
    localparam logic [CNT_W:0]   V_BLANK  = (CNT_W+1)'(VL_BLANK_START);
    localparam logic [CNT_W:0]   V_SYNC_S = (CNT_W+1)'(VL_SYNC_START);
    localparam logic [CNT_W:0]   V_SYNC_E = (CNT_W+1)'(VL_SYNC_END);
    localparam logic [2:0]       FILL_MAX = 3'(DELAY - 1);

    logic [CNT_W-1:0]   r_h_int, r_v_int;
    logic [CNT_W:0]     w_hx, w_vx;
    logic               w_hsync, w_vsync, w_hblnk, w_vblnk;

    logic [CNT_W-1:0]   r_h_pipe  [DELAY];
    logic [CNT_W-1:0]   r_v_pipe  [DELAY];
    logic               r_hs_pipe [DELAY];
    logic               r_vs_pipe [DELAY];
    logic               r_hb_pipe [DELAY];
    logic               r_vb_pipe [DELAY];

    logic [2:0]         r_fill;
    logic [CNT_W-1:0]   w_ld_h, w_ld_v;
    logic               w_line_load, w_frame_load;
    logic               r_line_start, r_frame_start, r_seen_frame;
    logic [FRAME_W-1:0] r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_int <= '0;
            r_v_int <= '0;
        end else if (en) begin
            if (r_h_int == H_LAST) begin
                r_h_int <= '0;
                r_v_int <= (r_v_int == V_LAST) ? '0 : r_v_int + CNT_W'(1);
            end else begin
                r_h_int <= r_h_int + CNT_W'(1);
            end
        end
    end

    // Zero-extend so a SYNC_END equal to 2**CNT_W still compares correctly.
    assign w_hx    = {1'b0, r_h_int};
    assign w_vx    = {1'b0, r_v_int};
    assign w_hsync = (w_hx >= H_SYNC_S && w_hx < H_SYNC_E) ? HSYNC_POL : ~HSYNC_POL;
    assign w_vsync = (w_vx >= V_SYNC_S && w_vx < V_SYNC_E) ? VSYNC_POL : ~VSYNC_POL;
    assign w_hblnk = (w_hx >= H_BLANK);
    assign w_vblnk = (w_vx >= V_BLANK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DELAY; i++) begin
                r_h_pipe[i]  <= '0;
                r_v_pipe[i]  <= '0;
                r_hs_pipe[i] <= ~HSYNC_POL;
                r_vs_pipe[i] <= ~VSYNC_POL;
                r_hb_pipe[i] <= 1'b0;
                r_vb_pipe[i] <= 1'b0;
            end
        end else if (en) begin
            r_h_pipe[0]  <= r_h_int;
            r_v_pipe[0]  <= r_v_int;
            r_hs_pipe[0] <= w_hsync;
            r_vs_pipe[0] <= w_vsync;
            r_hb_pipe[0] <= w_hblnk;
            r_vb_pipe[0] <= w_vblnk;
            for (int unsigned i = 1; i < DELAY; i++) begin
                r_h_pipe[i]  <= r_h_pipe[i-1];
                r_v_pipe[i]  <= r_v_pipe[i-1];
                r_hs_pipe[i] <= r_hs_pipe[i-1];
                r_vs_pipe[i] <= r_vs_pipe[i-1];
                r_hb_pipe[i] <= r_hb_pipe[i-1];
                r_vb_pipe[i] <= r_vb_pipe[i-1];
            end
        end
    end

    if (DELAY == 1) begin : g_src_direct
        assign w_ld_h = r_h_int;
        assign w_ld_v = r_v_int;
    end else begin : g_src_pipe
        assign w_ld_h = r_h_pipe[DELAY-2];
        assign w_ld_v = r_v_pipe[DELAY-2];
    end

    // Reset-fill entries reaching the last stage carry no real position, so pulses
    // wait until DELAY-1 loads have already happened.
    assign w_line_load  = en && (r_fill == FILL_MAX) && (w_ld_h == '0);
    assign w_frame_load = w_line_load && (w_ld_v == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill        <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_seen_frame  <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            if (en && r_fill != FILL_MAX) r_fill <= r_fill + 3'd1;
            r_line_start  <= w_line_load;
            r_frame_start <= w_frame_load;
            if (w_frame_load) begin
                if (r_seen_frame) r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
                r_seen_frame <= 1'b1;
            end
        end
    end

    assign hcount      = r_h_pipe[DELAY-1];
    assign vcount      = r_v_pipe[DELAY-1];
    assign hsync       = r_hs_pipe[DELAY-1];
    assign vsync       = r_vs_pipe[DELAY-1];
    assign hblnk       = r_hb_pipe[DELAY-1];
    assign vblnk       = r_vb_pipe[DELAY-1];
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: default-timing instance for line-level timing, plus a tiny-raster
// DELAY=3 active-high instance checked against an arithmetic position model.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        rst_a_n, en_a;
    logic [10:0] hcount_a, vcount_a;
    logic        hsync_a, vsync_a, hblnk_a, vblnk_a, ls_a, fs_a;
    logic [15:0] fc_a;

    vga_timing_gen dut_a (
        .clk(clk), .rst_n(rst_a_n), .en(en_a),
        .hcount(hcount_a), .vcount(vcount_a), .hsync(hsync_a), .vsync(vsync_a),
        .hblnk(hblnk_a), .vblnk(vblnk_a), .line_start(ls_a), .frame_start(fs_a),
        .frame_cnt(fc_a)
    );

    // Small raster instance: 8x4 raster, DELAY=3, active-high syncs, 2-bit frame counter
    logic       rst_b_n, en_b;
    logic [2:0] hcount_b, vcount_b;
    logic       hsync_b, vsync_b, hblnk_b, vblnk_b, ls_b, fs_b;
    logic [1:0] fc_b;

    vga_timing_gen #(
        .CNT_W(3),
        .HL_TOTAL_TIME(8), .HL_BLANK_START(4), .HL_SYNC_START(5), .HL_SYNC_END(6),
        .VL_TOTAL_TIME(4), .VL_BLANK_START(2), .VL_SYNC_START(3), .VL_SYNC_END(4),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .DELAY(3), .FRAME_W(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_b_n), .en(en_b),
        .hcount(hcount_b), .vcount(vcount_b), .hsync(hsync_b), .vsync(vsync_b),
        .hblnk(hblnk_b), .vblnk(vblnk_b), .line_start(ls_b), .frame_start(fs_b),
        .frame_cnt(fc_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int pack(input int h, input int v, input bit hs, input bit vs,
                                input bit hb, input bit vb, input bit ls, input bit fs,
                                input int fc);
        return (fc << 16) | (h << 8) | (v << 6) | (int'(hs) << 5) | (int'(vs) << 4) |
               (int'(hb) << 3) | (int'(vb) << 2) | (int'(ls) << 1) | int'(fs);
    endfunction

    function automatic int act_b();
        return pack(int'(hcount_b), int'(vcount_b), hsync_b, vsync_b, hblnk_b, vblnk_b,
                    ls_b, fs_b, int'(fc_b));
    endfunction

    // k = en-cycles since reset; the output shows the raster position from k-3 en-cycles
    // (position 0 while the pipe is still filling). ld = en was high on the last edge.
    function automatic int model_b(input int k, input bit ld);
        int p, h, v, fc;
        bit ls, fs;
        p  = (k < 3) ? 0 : (k - 3) % 32;
        h  = p % 8;
        v  = p / 8;
        fc = (k < 3) ? 0 : ((k - 3) / 32) % 4;
        ls = ld && (k >= 3) && (h == 0);
        fs = ls && (v == 0);
        return pack(h, v, (h >= 5 && h < 6), (v >= 3 && v < 4), (h >= 4), (v >= 2),
                    ls, fs, fc);
    endfunction

    typedef struct {
        bit en;
        int h;
        int v;
        bit hs;
        bit hb;
        bit ls;
        bit fs;
    } vec_t;

    vec_t tbl [13];
    int   fc_exp [5];

    initial begin
        int k, n, hs_low, hb_high, nfs, first, second, consec, frozen_bad;
        bit prev_ls, en_now;
        logic [10:0] h_before;

        // en, h, v, hs, hb, ls, fs for dut_b straight after reset (v stays 0/1, no vsync/vblank)
        tbl[0]  = '{1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 4, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 5, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 5, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 6, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 7, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0};
        fc_exp  = '{0, 1, 2, 3, 0};

        en_a = 1'b0; en_b = 1'b0; rst_a_n = 1'b0; rst_b_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_b_outputs", act_b(), pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("rst_a_syncs", int'({hsync_a, vsync_a}), 3);
        chk("rst_a_rest", int'({hcount_a, vcount_a, hblnk_a, vblnk_a, ls_a, fs_a, fc_a}), 0);
        rst_a_n = 1'b1; rst_b_n = 1'b1;

        k = 0;
        for (int i = 0; i < 13; i++) begin
            en_b = tbl[i].en;
            @(posedge clk); #1;
            if (en_b) k++;
            chk($sformatf("tbl%0d", i), act_b(),
                pack(tbl[i].h, tbl[i].v, tbl[i].hs, 1'b0, tbl[i].hb, 1'b0,
                     tbl[i].ls, tbl[i].fs, 0));
        end

        for (int c = 0; c < 1500; c++) begin
            en_b = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            if (en_b) k++;
            chk("rand_model", act_b(), model_b(k, en_b));
            if (c == 600) begin
                rst_b_n = 1'b0;
                #1;
                chk("async_rst_mid", act_b(), pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
                @(posedge clk); #1;
                rst_b_n = 1'b1;
                k = 0;
            end
        end

        // Frame counter wrap sequence on the 2-bit counter
        rst_b_n = 1'b0; #1; rst_b_n = 1'b1;
        en_b = 1'b1;
        nfs = 0;
        for (int c = 0; c < 400 && nfs < 5; c++) begin
            @(posedge clk); #1;
            if (fs_b) begin
                chk($sformatf("fc_seq%0d", nfs), int'(fc_b), fc_exp[nfs]);
                nfs++;
            end
        end
        chk("fc_seq_len", nfs, 5);
        en_b = 1'b0;

        // Default timing: first en gives both pulses, then one full line
        en_a = 1'b1;
        @(posedge clk); #1;
        chk("a_first_pulses", int'({ls_a, fs_a}), 3);
        n = 0; hs_low = 0; hb_high = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (!hsync_a) hs_low++;
            if (hblnk_a) hb_high++;
        end while (!ls_a && n < 3000);
        chk("a_line_period", n, 1344);
        chk("a_hsync_low", hs_low, 136);
        chk("a_hblnk_high", hb_high, 320);
        chk("a_frame_cnt_first", int'(fc_a), 0);
        chk("a_vcount_line1", int'(vcount_a), 1);

        // en toggling every clock
        rst_a_n = 1'b0; #1; rst_a_n = 1'b1;
        en_a = 1'b1;
        first = -1; second = -1; consec = 0; frozen_bad = 0; prev_ls = 1'b0;
        for (int c = 0; c < 6000 && second < 0; c++) begin
            en_now = en_a;
            h_before = hcount_a;
            @(posedge clk); #1;
            if (!en_now && hcount_a != h_before) frozen_bad++;
            if (ls_a && prev_ls) consec++;
            if (ls_a) begin
                if (first < 0) first = c;
                else second = c;
            end
            prev_ls = ls_a;
            en_a = ~en_a;
        end
        chk("toggle_line_period", second - first, 2688);
        chk("toggle_pulse_width", consec, 0);
        chk("toggle_frozen", frozen_bad, 0);
        en_a = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
